// File: rtl/freq_classifier.sv
// -----------------------------------------------------------------------------
// freq_classifier
//
// Purpose:
//    Classifies a once-per-window frequency measurement (Hz) into one of three
//    inclusive bands and locks onto a band only after CONFIRM consecutive
//    matching windows. The lock is released only after RELEASE consecutive
//    non-matching windows. A window ends on every level change of OneSecond.
//
// Pipeline, relative to the edge e1 at which a OneSecond toggle is detected:
//    e1 : toggle seen (OneSecond != prev_sec), stage 1 armed
//    e2 : stage 2 armed
//    e3 : Hz captured into last_hz, sample_strobe asserted
//    e4 : FSM evaluates the class of last_hz; band/locked/band_change update
//
// Ports:
//    clk           in   system clock, all logic on posedge
//    reset         in   synchronous active-high reset
//    OneSecond     in   window marker, each level change closes a window
//    Hz     [9:0]  in   measured cycles-per-second from the upstream counter
//    band   [1:0]  out  locked band (0 none, 1..3)
//    locked        out  high while band != 0
//    band_change   out  one-cycle pulse when band changes value
//    last_hz [9:0] out  Hz value captured for the most recent window
//    sample_strobe out  one-cycle pulse when last_hz is updated
// -----------------------------------------------------------------------------
module freq_classifier #(
   parameter int B1_LO   = 90,
   parameter int B1_HI   = 110,
   parameter int B2_LO   = 190,
   parameter int B2_HI   = 210,
   parameter int B3_LO   = 490,
   parameter int B3_HI   = 510,
   parameter int CONFIRM = 3,
   parameter int RELEASE = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       OneSecond,
   input  logic [9:0] Hz,
   output logic [1:0] band,
   output logic       locked,
   output logic       band_change,
   output logic [9:0] last_hz,
   output logic       sample_strobe
);

   localparam logic [9:0] B1_LO_C   = 10'(B1_LO);
   localparam logic [9:0] B1_HI_C   = 10'(B1_HI);
   localparam logic [9:0] B2_LO_C   = 10'(B2_LO);
   localparam logic [9:0] B2_HI_C   = 10'(B2_HI);
   localparam logic [9:0] B3_LO_C   = 10'(B3_LO);
   localparam logic [9:0] B3_HI_C   = 10'(B3_HI);
   localparam logic [9:0] HZ_SAT    = 10'd1023;
   localparam logic [2:0] CONFIRM_C = 3'(CONFIRM);
   localparam logic [2:0] RELEASE_C = 3'(RELEASE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAND = 2'd1,
      LOCK = 2'd2,
      LOSE = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Window detection and sample pipeline
   // ---------------------------------------------------------------------------
   logic       prev_sec_q;
   logic       stage1_q;
   logic       stage2_q;
   logic       pend_q;
   logic       strobe_q;
   logic [9:0] last_hz_q;

   logic toggle;
   logic busy;
   logic start;

   assign toggle = (OneSecond != prev_sec_q);
   // Only the two pre-capture stages can collide with a new window; the
   // capture/evaluate cycles never overlap the next capture.
   assign busy   = stage1_q | stage2_q;
   assign start  = (toggle | pend_q) & ~busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         // Track the input during reset so release never looks like a toggle.
         prev_sec_q <= OneSecond;
         stage1_q   <= 1'b0;
         stage2_q   <= 1'b0;
         pend_q     <= 1'b0;
         strobe_q   <= 1'b0;
         last_hz_q  <= '0;
      end else begin
         prev_sec_q <= OneSecond;
         stage1_q   <= start;
         stage2_q   <= stage1_q;
         strobe_q   <= stage2_q;
         // One window of queueing: a toggle arriving while busy is held
         // until the in-flight window has left the pre-capture stages.
         if (busy && toggle) begin
            pend_q <= 1'b1;
         end else if (start) begin
            pend_q <= 1'b0;
         end
         if (stage2_q) begin
            last_hz_q <= Hz;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Classification of the captured value
   // ---------------------------------------------------------------------------
   function automatic logic [1:0] classify(input logic [9:0] hz);
      logic [1:0] c;
      c = 2'd0;
      // A saturated upstream count is never trusted, whatever the bounds.
      if (hz == HZ_SAT) begin
         c = 2'd0;
      end else if (hz >= B1_LO_C && hz <= B1_HI_C) begin
         c = 2'd1;
      end else if (hz >= B2_LO_C && hz <= B2_HI_C) begin
         c = 2'd2;
      end else if (hz >= B3_LO_C && hz <= B3_HI_C) begin
         c = 2'd3;
      end
      return c;
   endfunction

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v == 3'd7) ? 3'd7 : v + 3'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // Lock FSM, evaluated in the cycle after each capture
   // ---------------------------------------------------------------------------
   state_t     state_q;
   logic [1:0] cand_q;
   logic [1:0] band_q;
   logic [2:0] cnt_q;
   logic [2:0] miss_q;
   logic       band_change_q;

   logic [1:0] cls;
   logic [2:0] cnt_inc;
   logic [2:0] miss_next;

   // NOTE: every combinationally assigned signal gets a value on every path
   // (here by continuous assignment) so no latch can be inferred.
   assign cls       = classify(last_hz_q);
   assign cnt_inc   = sat_inc(cnt_q);
   // Entering LOSE from LOCK always starts the miss count at one.
   assign miss_next = (state_q == LOCK) ? 3'd1 : sat_inc(miss_q);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register in this block sees the pre-edge value of every other one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cand_q        <= 2'd0;
         band_q        <= 2'd0;
         cnt_q         <= 3'd0;
         miss_q        <= 3'd0;
         band_change_q <= 1'b0;
      end else begin
         band_change_q <= 1'b0;
         if (strobe_q) begin
            case (state_q)
               IDLE: begin
                  if (cls != 2'd0) begin
                     cand_q <= cls;
                     cnt_q  <= 3'd1;
                     if (CONFIRM_C == 3'd1) begin
                        state_q       <= LOCK;
                        band_q        <= cls;
                        band_change_q <= 1'b1;
                     end else begin
                        state_q <= CAND;
                     end
                  end
               end

               CAND: begin
                  if (cls == 2'd0) begin
                     state_q <= IDLE;
                     cnt_q   <= 3'd0;
                  end else if (cls == cand_q) begin
                     cnt_q <= cnt_inc;
                     if (cnt_inc >= CONFIRM_C) begin
                        state_q       <= LOCK;
                        band_q        <= cand_q;
                        band_change_q <= (cand_q != band_q);
                     end
                  end else begin
                     cand_q <= cls;
                     cnt_q  <= 3'd1;
                  end
               end

               LOCK, LOSE: begin
                  if (cls == band_q) begin
                     state_q <= LOCK;
                     miss_q  <= 3'd0;
                  end else if (miss_next >= RELEASE_C) begin
                     // Lock dropped; the current window may already seed a
                     // new candidate.
                     band_q        <= 2'd0;
                     band_change_q <= 1'b1;
                     miss_q        <= 3'd0;
                     if (cls == 2'd0) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                     end else begin
                        state_q <= CAND;
                        cand_q  <= cls;
                        cnt_q   <= 3'd1;
                     end
                  end else begin
                     state_q <= LOSE;
                     miss_q  <= miss_next;
                  end
               end

               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign band          = band_q;
   assign locked        = (band_q != 2'd0);
   assign band_change   = band_change_q;
   assign last_hz       = last_hz_q;
   assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_freq_classifier.sv
// -----------------------------------------------------------------------------
// tb_freq_classifier
//
// Directed windows are issued by the stimulus process, which pushes the
// expected captured Hz and the expected band/band_change after evaluation
// into a queue. A monitor pops an entry on every sample_strobe, checks
// last_hz, then checks band/locked/band_change one cycle later.
// -----------------------------------------------------------------------------
module tb_freq_classifier;

   logic       clk;
   logic       reset;
   logic       OneSecond;
   logic [9:0] Hz;
   logic [1:0] band;
   logic       locked;
   logic       band_change;
   logic [9:0] last_hz;
   logic       sample_strobe;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] hz;
      logic [1:0] band;
      logic       chg;
   } exp_t;

   exp_t exp_q[$];

   freq_classifier dut (
      .clk          (clk),
      .reset        (reset),
      .OneSecond    (OneSecond),
      .Hz           (Hz),
      .band         (band),
      .locked       (locked),
      .band_change  (band_change),
      .last_hz      (last_hz),
      .sample_strobe(sample_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: samples 1 time unit after each rising edge
   // ---------------------------------------------------------------------------
   exp_t cur;
   logic eval_pend = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (eval_pend) begin
            check("eval_band", 32'(band), 32'(cur.band));
            check("eval_locked", 32'(locked), 32'(cur.band != 2'd0));
            check("eval_band_change", 32'(band_change), 32'(cur.chg));
            eval_pend = 1'b0;
         end else if (!reset && band_change) begin
            check("spurious_band_change", 32'(band_change), 32'd0);
         end
         if (sample_strobe) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 32'(sample_strobe), 32'd0);
            end else begin
               cur = exp_q.pop_front();
               check("last_hz", 32'(last_hz), 32'(cur.hz));
               eval_pend = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic push_exp(input logic [9:0] hz, input logic [1:0] b, input logic chg);
      exp_t e;
      e.hz   = hz;
      e.band = b;
      e.chg  = chg;
      exp_q.push_back(e);
   endtask

   // One measurement window: toggle OneSecond with Hz valid, then idle long
   // enough for capture and evaluation to complete.
   task automatic win(input logic [9:0] hz, input logic [1:0] b, input logic chg);
      @(negedge clk);
      Hz        = hz;
      OneSecond = ~OneSecond;
      push_exp(hz, b, chg);
      repeat (6) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      OneSecond = 1'b1;
      Hz        = 10'd0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_band", 32'(band), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_band_change", 32'(band_change), 32'd0);
      check("rst_sample_strobe", 32'(sample_strobe), 32'd0);
      check("rst_last_hz", 32'(last_hz), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      // No window may appear on reset release alone.
      check("release_no_strobe_hz", 32'(last_hz), 32'd0);

      // Lock on band 1 after three matching windows
      win(10'd100, 2'd0, 1'b0);
      win(10'd100, 2'd0, 1'b0);
      win(10'd100, 2'd1, 1'b1);

      // Two misses drop the lock, FSM back to IDLE
      win(10'd300, 2'd1, 1'b0);
      win(10'd300, 2'd0, 1'b1);

      // From IDLE: first 200 starts a candidate; the next two windows arrive
      // back to back and the second one is queued behind the first.
      win(10'd200, 2'd0, 1'b0);
      @(negedge clk);
      OneSecond = ~OneSecond;
      push_exp(10'd200, 2'd0, 1'b0);
      @(negedge clk);
      OneSecond = ~OneSecond;
      push_exp(10'd200, 2'd2, 1'b1);
      repeat (10) @(negedge clk);

      // Locked on band 2: single miss is absorbed
      win(10'd200, 2'd2, 1'b0);
      win(10'd0,   2'd2, 1'b0);
      win(10'd205, 2'd2, 1'b0);

      // Drop to IDLE, then candidate restarts before locking on band 1
      win(10'd0, 2'd2, 1'b0);
      win(10'd0, 2'd0, 1'b1);
      win(10'd500, 2'd0, 1'b0);
      win(10'd500, 2'd0, 1'b0);
      win(10'd100, 2'd0, 1'b0);
      win(10'd100, 2'd0, 1'b0);
      win(10'd100, 2'd1, 1'b1);

      // Drop to IDLE, then band edges and saturation never lock
      win(10'd0, 2'd1, 1'b0);
      win(10'd0, 2'd0, 1'b1);
      win(10'd110,  2'd0, 1'b0);
      win(10'd111,  2'd0, 1'b0);
      win(10'd1023, 2'd0, 1'b0);

      // Band 3 inclusive edges lock
      win(10'd490, 2'd0, 1'b0);
      win(10'd490, 2'd0, 1'b0);
      win(10'd510, 2'd3, 1'b1);

      // Reset one cycle after a toggle: pending sample is discarded
      @(negedge clk);
      Hz        = 10'd100;
      OneSecond = ~OneSecond;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_rst_last_hz", 32'(last_hz), 32'd0);
      check("mid_rst_band", 32'(band), 32'd0);
      check("mid_rst_locked", 32'(locked), 32'd0);

      // Every issued window must have been observed
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_classifier.md
FREQ_CLASSIFIER -- requirements
Module: freq_classifier

Interface
REQ-001 Parameter B1_LO, default 90, lower inclusive Hz bound of band 1.
REQ-002 Parameter B1_HI, default 110, upper inclusive Hz bound of band 1.
REQ-003 Parameter B2_LO, default 190, lower inclusive bound of band 2.
REQ-004 Parameter B2_HI, default 210, upper inclusive bound of band 2.
REQ-005 Parameter B3_LO, default 490, lower inclusive bound of band 3.
REQ-006 Parameter B3_HI, default 510, upper inclusive bound of band 3.
REQ-007 Parameter CONFIRM, default 3, consecutive matching windows required to lock (legal 1..7).
REQ-008 Parameter RELEASE, default 2, consecutive non-matching windows required to drop lock (legal 1..7).
REQ-009 clk  input  1  100 MHz system clock; all logic on posedge clk.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 OneSecond  input  1  window marker; every level change (either direction) ends one measurement window.
REQ-012 Hz  input  10  cycles-per-second count from the upstream edge counter, updated on the clock edge at which that counter sees the OneSecond toggle.
REQ-013 band  output  2  locked band: 0 none, 1/2/3 per bounds.
REQ-014 locked  output  1  high while band != 0.
REQ-015 band_change  output  1  one-cycle pulse when band changes value.
REQ-016 last_hz  output  10  Hz value sampled at the most recent window.
REQ-017 sample_strobe  output  1  one-cycle pulse when last_hz is updated.

Function
REQ-018 Window detect: register OneSecond into prev_sec every cycle; toggle = OneSecond != prev_sec; no toggle is lost or double-counted for toggles spaced >= 3 cycles apart.
REQ-019 Sampling: Hz is captured into last_hz exactly 2 cycles after the toggle-detect cycle; sample_strobe asserts on that same capture edge for 1 cycle.
REQ-020 Classification of the captured value (combinational on last_hz, used the cycle after capture): band 1/2/3 if within the inclusive bounds, checked in order 1,2,3; else class 0; Hz == 1023 always class 0 (saturated upstream).
REQ-021 FSM states: IDLE, CAND, LOCK, LOSE; evaluated once per window, one cycle after sample_strobe; state held between windows.
REQ-022 IDLE: class != 0 -> CAND, cand = class, cnt = 1 (if CONFIRM == 1 go directly to LOCK).
REQ-023 CAND: class == cand -> cnt+1; when cnt reaches CONFIRM -> LOCK, band = cand; class != cand and != 0 -> restart CAND with new cand, cnt = 1; class == 0 -> IDLE.
REQ-024 LOCK: class == band -> stay; otherwise -> LOSE, miss = 1 (if RELEASE == 1 apply drop immediately).
REQ-025 LOSE: class == band -> LOCK, miss = 0; otherwise miss+1; when miss reaches RELEASE -> band = 0, then IDLE if class == 0, else CAND with cand = class, cnt = 1.
REQ-026 band, locked update on the FSM evaluation edge; band_change pulses on that edge iff band's new value differs from its old value.
REQ-027 Counters cnt, miss are 3 bits, saturate at 7, never wrap.
REQ-028 Toggle arriving while a sample/evaluate pipeline is in flight (spacing < 3 cycles): the pending window completes; the new toggle is processed after it (queue depth 1).

Reset
REQ-029 While reset is high at a clock edge: state = IDLE, band = 0, locked = 0, band_change = 0, sample_strobe = 0, last_hz = 0, cnt = miss = 0, prev_sec = OneSecond (no spurious window on release).
REQ-030 Reset asserted mid-pipeline discards any pending sample; first window after release requires a fresh OneSecond toggle.

Verification
REQ-031 Reset release, then 3 windows with Hz = 100 -> sample_strobe each window; band = 1, locked = 1, band_change pulse on 3rd evaluation only.
REQ-032 Locked on band 1, windows Hz = 300, 300 -> band = 0 on 2nd evaluation with band_change pulse; FSM IDLE.
REQ-033 Locked on band 2, windows Hz = 200, 0, 205 -> band stays 2 throughout, no band_change pulse.
REQ-034 Windows Hz = 500, 500, 100, 100, 100 -> no lock until 5th evaluation, then band = 1.
REQ-035 Windows Hz = 110, 111, 1023 -> classes 1, 0, 0; never locks; last_hz tracks 110, 111, 1023.
REQ-036 Reset asserted 1 cycle after a toggle with Hz = 100 pending -> no sample_strobe, last_hz = 0, band = 0 after release.
